// File: rtl/stream_fork_n_pkg.sv
// Shared types for the stream fork: the two-state view of its bookkeeping.
package stream_fork_n_pkg;

  typedef enum logic {
    FORK_IDLE = 1'b0,
    FORK_WAIT = 1'b1
  } fork_state_e;

  // IDLE when no output holds the current beat yet, WAIT once any output has it.
  function automatic fork_state_e fork_state(input logic any_sent);
    return any_sent ? FORK_WAIT : FORK_IDLE;
  endfunction

endpackage

// File: rtl/stream_fork_n.sv
// Handshake-only fork of one valid/ready stream into N_OUP streams; the input
// beat is consumed once every output has taken it, in any order.
module stream_fork_n
  import stream_fork_n_pkg::*;
#(
  parameter int N_OUP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [N_OUP-1:0] valid_o,
  input  logic [N_OUP-1:0] ready_i
);

  if (N_OUP < 1) begin : g_bad_n_oup
    $error("stream_fork_n: N_OUP must be at least 1");
  end

  logic [N_OUP-1:0] sent_q;
  logic [N_OUP-1:0] sent_d;
  logic             done;

  // A completed beat clears the bookkeeping; otherwise accumulate acceptances.
  always_comb begin
    done   = &(ready_i | sent_q);
    sent_d = sent_q;
    if (valid_i) begin
      sent_d = done ? '0 : (sent_q | ready_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

  // Outputs are gated during reset so no handshake can complete then.
  assign valid_o = {N_OUP{valid_i & ~rst_i}} & ~sent_q;
  assign ready_o = valid_i & ~rst_i & done;

  a_valid_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o) |=> valid_i)
    else $error("stream_fork_n: valid_i dropped before ready_o");

  a_ready_needs_valid : assert property (@(posedge clk_i)
    ready_o |-> valid_i)
    else $error("stream_fork_n: ready_o without valid_i");

  a_idle_after_done : assert property (@(posedge clk_i) disable iff (rst_i)
    ready_o |=> (fork_state(|sent_q) == FORK_IDLE))
    else $error("stream_fork_n: bookkeeping not cleared after completion");

endmodule

// File: tb/tb_stream_fork_n.sv
// Scoreboard bench for stream_fork_n: a 3-output and a 1-output instance driven
// by directed and random handshakes, checked against a per-beat model.
module tb_stream_fork_n;

  logic       clk;
  logic       rst;
  logic       v3;
  logic [2:0] r3;
  logic       rdy3;
  logic [2:0] vo3;
  logic       v1;
  logic       r1;
  logic       rdy1;
  logic       vo1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] vo3;
    logic       ro3;
    logic       vo1;
    logic       ro1;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  // Model state: which outputs of the 3-way fork already hold the current beat.
  bit   served[3];
  bit   pend3;
  bit   pend1;

  stream_fork_n #(.N_OUP(3)) u_fork3 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(v3),
    .ready_o(rdy3),
    .valid_o(vo3),
    .ready_i(r3)
  );

  stream_fork_n #(.N_OUP(1)) u_fork1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(v1),
    .ready_o(rdy1),
    .valid_o(vo1),
    .ready_i(r1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".valid_o3"}, vo3, e.vo3);
      chk({e.tag, ".ready_o3"}, {2'b00, rdy3}, {2'b00, e.ro3});
      chk({e.tag, ".valid_o1"}, {2'b00, vo1}, {2'b00, e.vo1});
      chk({e.tag, ".ready_o1"}, {2'b00, rdy1}, {2'b00, e.ro1});
    end
  end

  // One cycle of stimulus: apply inputs, predict outputs, then advance the model.
  task automatic step(input string tag, input logic rs, input logic v,
                      input logic [2:0] r, input logic va, input logic ra);
    exp_t e;
    int   covered;
    @(posedge clk);
    #1;
    rst = rs; v3 = v; r3 = r; v1 = va; r1 = ra;
    covered = 0;
    for (int i = 0; i < 3; i++) begin
      e.vo3[i] = v && !rs && !served[i];
      if (served[i] || r[i]) covered++;
    end
    e.ro3 = v && !rs && (covered == 3);
    e.vo1 = va && !rs;
    e.ro1 = va && ra && !rs;
    e.tag = tag;
    exp_q.push_back(e);
    if (rs || e.ro3) begin
      for (int i = 0; i < 3; i++) served[i] = 1'b0;
    end else if (v) begin
      for (int i = 0; i < 3; i++) if (r[i]) served[i] = 1'b1;
    end
    pend3 = !rs && v && !e.ro3;
    pend1 = !rs && va && !e.ro1;
  endtask

  initial begin
    rst = 1'b1; v3 = 1'b0; r3 = 3'b000; v1 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 3; i++) served[i] = 1'b0;
    pend3 = 1'b0;
    pend1 = 1'b0;

    step("reset",      1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    step("reset_busy", 1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
    step("all_ready",  1'b0, 1'b1, 3'b111, 1'b0, 1'b0);
    step("next_beat",  1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    step("part_c0",    1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    step("part_c1",    1'b0, 1'b1, 3'b100, 1'b0, 1'b0);
    step("part_c2",    1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
    step("part_c3",    1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    step("resend_a",   1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    step("resend_b",   1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
    step("resend_c",   1'b0, 1'b1, 3'b101, 1'b0, 1'b0);
    step("idle_a",     1'b0, 1'b0, 3'b111, 1'b0, 1'b1);
    step("idle_b",     1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    step("idle_after", 1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
    step("mid_rst",    1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    step("post_rst",   1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    step("post_rst_b", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic       rs;
      logic       v;
      logic       va;
      logic [2:0] r;
      rs = ($urandom_range(0, 39) == 0);
      v  = pend3 ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      va = pend1 ? 1'b1 : 1'($urandom_range(0, 1));
      r  = 3'($urandom_range(0, 7));
      step("random", rs, v, r, va, 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
